phys_reg_freelist: RTL
======================

PHYS_REG_FREELIST -- requirements
Module: phys_reg_freelist

Interface
REQ-001 SHALL have parameter NUM_PHY_REGS, default 64, giving the physical register count (power of two, at least 64).
REQ-002 SHALL have parameter NUM_SICS, default 2, giving the number of alloc ports and the number of free ports.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port alloc_req[NUM_SICS], input, 1 bit each: the Issue Controller requests one new PR on port s.
REQ-006 SHALL have port alloc_wen[NUM_SICS], output, 1 bit each: grant on port s; drives the register file alloc_wen directly.
REQ-007 SHALL have port alloc_pr[NUM_SICS], output, $clog2(NUM_PHY_REGS) bits each: the granted PR; drives the register file alloc_pr.
REQ-008 SHALL have port free_wen[NUM_SICS], input, 1 bit each: return of one PR on port s (old mapping retired).
REQ-009 SHALL have port free_pr[NUM_SICS], input, $clog2(NUM_PHY_REGS) bits each: the PR being returned.
REQ-010 SHALL have port free_count, output, $clog2(NUM_PHY_REGS)+1 bits: entries currently in the list (registered).
REQ-011 SHALL have port alloc_ready, output, 1 bit: 1 when free_count >= NUM_SICS (registered).

Function
REQ-012 SHALL hold free PR indices in a circular FIFO of NUM_PHY_REGS entries, with head and tail pointers of $clog2(NUM_PHY_REGS) bits that wrap modulo NUM_PHY_REGS.
REQ-013 SHALL hold a per-PR in_list bit, set on push and cleared on pop.
REQ-014 SHALL grant alloc_wen combinationally in the same cycle as the request; port s is granted iff alloc_req[s]=1 and free_count > (number of grants on ports < s).
REQ-015 SHALL give the k-th grant of a cycle (k from 0, ascending port order) alloc_pr = fifo[head+k]; an ungranted port drives alloc_wen=0 and alloc_pr=0.
REQ-016 SHALL advance head by the grant count at the clock edge and clear in_list for each granted PR.
REQ-017 SHALL push, for each port with free_wen[s]=1 and free_pr[s]!=0, free_pr[s] at fifo[tail+j], where j is the rank of s among accepted frees in ascending port order; tail advances by the accepted count.
REQ-018 SHALL silently ignore a free of PR0, which never enters the list.
REQ-019 SHALL not bypass frees to allocs: PRs freed in cycle N are first grantable in cycle N+1, and free_count at the start of cycle N alone bounds grants in cycle N.
REQ-020 SHALL update free_count each edge as free_count + accepted frees - grants, where simultaneous alloc and free in one cycle are legal.
REQ-021 SHALL, in simulation only ($fatal when SYNTHESIS is undefined), fail on: a free of a PR whose in_list=1 (double free); the same non-zero PR on two free ports in one cycle; a push that would make free_count exceed NUM_PHY_REGS-1.
REQ-022 SHALL never output PR0 on alloc_pr while alloc_wen=1.
REQ-023 SHALL have no deadlock: with free_count=0, all grants are 0 and requests may stay asserted indefinitely.

Reset
REQ-024 SHALL, when rst_n=0 at an edge, load fifo[i] = 32+i for i in 0..NUM_PHY_REGS-33, set head=0, tail=NUM_PHY_REGS-32 and free_count=NUM_PHY_REGS-32.
REQ-025 SHALL, on reset, set in_list=1 for PR 32..NUM_PHY_REGS-1 and in_list=0 for PR 0..31, since PR 0..31 hold the initial architectural mapping.
REQ-026 SHALL, on reset, make alloc_ready = (NUM_PHY_REGS-32 >= NUM_SICS) from the next cycle.
REQ-027 SHALL let reset mid-operation discard all in-flight state with no pending free retained; during reset alloc_wen SHALL be 0.

Verification
REQ-028 SHALL cover: after reset, alloc_req={1,1} for one cycle -> alloc_wen={1,1}, alloc_pr={32,33}; next cycle free_count=30.
REQ-029 SHALL cover: 32 single-port allocs -> PRs 32..63 in order; free_count=0, alloc_ready=0; a further alloc_req[0] -> alloc_wen[0]=0.
REQ-030 SHALL cover: with free_count=1, alloc_req={1,1} -> only port 0 granted; port 1 gets alloc_wen=0 and alloc_pr=0.
REQ-031 SHALL cover: with free_count=0, free_pr={5,0} plus alloc_req[0] in the same cycle -> no grant that cycle; next cycle alloc_pr[0]=5; the PR0 free is ignored (free_count=1 after the push).
REQ-032 SHALL cover: 63 frees/allocs cycled across head/tail wrap -> FIFO order preserved across the index 63->0 boundary and free_count stays consistent.
REQ-033 SHALL cover: free of PR 40 while in_list[40]=1 -> simulation $fatal (double free).

Source files
------------

// File: rtl/phys_reg_freelist_if.sv
// Alloc/free handshake bundle between the Issue Controller (master)
// and the physical register free list (slave).
interface phys_reg_freelist_if #(
  parameter int NUM_PHY_REGS = 64,
  parameter int NUM_SICS     = 2
);
  localparam int PW = $clog2(NUM_PHY_REGS);

  logic          alloc_req  [NUM_SICS];
  logic          alloc_wen  [NUM_SICS];
  logic [PW-1:0] alloc_pr   [NUM_SICS];
  logic          free_wen   [NUM_SICS];
  logic [PW-1:0] free_pr    [NUM_SICS];
  logic [PW:0]   free_count;
  logic          alloc_ready;

  modport master (
    output alloc_req, free_wen, free_pr,
    input  alloc_wen, alloc_pr, free_count, alloc_ready
  );

  modport slave (
    input  alloc_req, free_wen, free_pr,
    output alloc_wen, alloc_pr, free_count, alloc_ready
  );
endinterface

// File: rtl/phys_reg_freelist.sv
// Circular-FIFO free list of physical registers: multi-port same-cycle
// grants from the head, multi-port returns pushed at the tail.
module phys_reg_freelist #(
  parameter int NUM_PHY_REGS = 64,
  parameter int NUM_SICS     = 2
) (
  input logic               clk,
  input logic               rst_n,
  phys_reg_freelist_if.slave bus
);
  localparam int          PW    = $clog2(NUM_PHY_REGS);
  localparam int          CW    = PW + 1;
  localparam int unsigned NINIT = NUM_PHY_REGS - 32;

  logic [PW-1:0] r_fifo    [NUM_PHY_REGS];
  logic          r_in_list [NUM_PHY_REGS];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_ready;

  logic [CW-1:0] w_ngrant;
  logic [CW-1:0] w_nfree;
  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] w_rd_idx [NUM_SICS];
  logic [PW-1:0] w_wr_idx [NUM_SICS];
  logic          w_push   [NUM_SICS];

  assign bus.free_count  = r_count;
  assign bus.alloc_ready = r_ready;

  // Grants are bounded by the registered count only, so a PR freed this
  // cycle can never be handed out before the next cycle.
  always_comb begin
    w_ngrant = '0;
    for (int unsigned s = 0; s < NUM_SICS; s++) begin
      bus.alloc_wen[s] = 1'b0;
      bus.alloc_pr[s]  = '0;
      w_rd_idx[s]      = r_head + w_ngrant[PW-1:0];
      if (rst_n && bus.alloc_req[s] && (r_count > w_ngrant)) begin
        bus.alloc_wen[s] = 1'b1;
        bus.alloc_pr[s]  = r_fifo[w_rd_idx[s]];
        w_ngrant         = w_ngrant + CW'(1);
      end
    end
  end

  always_comb begin
    w_nfree = '0;
    for (int unsigned s = 0; s < NUM_SICS; s++) begin
      w_push[s]   = bus.free_wen[s] && (bus.free_pr[s] != '0);
      w_wr_idx[s] = r_tail + w_nfree[PW-1:0];
      if (w_push[s]) begin
        w_nfree = w_nfree + CW'(1);
      end
    end
  end

  assign w_count_nxt = r_count + w_nfree - w_ngrant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PHY_REGS; i++) begin
        r_fifo[i]    <= (i < NINIT) ? PW'(32 + i) : '0;
        r_in_list[i] <= (i >= 32);
      end
      r_head  <= '0;
      r_tail  <= PW'(NINIT);
      r_count <= CW'(NINIT);
      r_ready <= (NINIT >= NUM_SICS);
    end else begin
      r_head  <= r_head + w_ngrant[PW-1:0];
      r_tail  <= r_tail + w_nfree[PW-1:0];
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt >= CW'(NUM_SICS));
      for (int unsigned s = 0; s < NUM_SICS; s++) begin
        if (bus.alloc_wen[s]) begin
          r_in_list[bus.alloc_pr[s]] <= 1'b0;
        end
      end
      for (int unsigned s = 0; s < NUM_SICS; s++) begin
        if (w_push[s]) begin
          r_fifo[w_wr_idx[s]]       <= bus.free_pr[s];
          r_in_list[bus.free_pr[s]] <= 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned s = 0; s < NUM_SICS; s++) begin
        if (w_push[s] && r_in_list[bus.free_pr[s]]) begin
          $fatal(1, "phys_reg_freelist: double free of PR %0d", bus.free_pr[s]);
        end
        for (int unsigned t = s + 1; t < NUM_SICS; t++) begin
          if (w_push[s] && w_push[t] && (bus.free_pr[s] == bus.free_pr[t])) begin
            $fatal(1, "phys_reg_freelist: PR %0d freed on two ports", bus.free_pr[s]);
          end
        end
      end
      if (w_count_nxt > CW'(NUM_PHY_REGS - 1)) begin
        $fatal(1, "phys_reg_freelist: free list overflow");
      end
    end
  end
`endif
endmodule
